// File: rtl/fft_pkg.sv
// Shared constants and helpers for the FIR-to-FFT datapath.
// The bit-reverse helper is also used by the FFT stage.
package fft_pkg;

    localparam int unsigned DW    = 16;
    localparam int unsigned N     = 16;
    localparam int unsigned LOG2N = 4;
    localparam int unsigned FCW   = 8;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame bank: N x DW registers with a single write port
// and all slots visible on a flat read bus.
module fft_frame_bank #(
    parameter int unsigned DW    = 16,
    parameter int unsigned N     = 16,
    parameter int unsigned LOG2N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [LOG2N-1:0]     waddr,
    input  logic [DW-1:0]        wdata,
    output logic [N*DW-1:0]      rdata
);

    logic [N-1:0][DW-1:0] mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem;

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer between the FIR and FFT stages.
// Define FFT_FRAME_BUFFER_BITREV_EN to store frames in bit-reversed slot order.
module fft_frame_buffer
    import fft_pkg::*;
#(
    parameter int unsigned DW    = fft_pkg::DW,
    parameter int unsigned N     = fft_pkg::N,
    parameter int unsigned LOG2N = fft_pkg::LOG2N
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DW-1:0]        in_data,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic [N*DW-1:0]      frame_data,
    output logic [FCW-1:0]       frame_cnt,
    output logic                 overflow
);

    logic [1:0]          full;
    logic [1:0]          full_nxt;
    logic                wr_bank;
    logic                rd_bank;
    logic [LOG2N-1:0]    wr_cnt;
    logic [LOG2N-1:0]    waddr;
    logic                write;
    logic                drop;
    logic                xfer;
    logic                wr_last;
    logic [N*DW-1:0]     bank_data [2];

    assign write   = in_valid & ~full[wr_bank];
    assign drop    = in_valid &  full[wr_bank];
    assign xfer    = full[rd_bank] & frame_ready;
    assign wr_last = (wr_cnt == LOG2N'(N-1));

`ifdef FFT_FRAME_BUFFER_BITREV_EN
    assign waddr = bitrev(wr_cnt);
`else
    assign waddr = wr_cnt;
`endif

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank #(
            .DW   (DW),
            .N    (N),
            .LOG2N(LOG2N)
        ) u_bank (
            .clk  (clk),
            .rst  (rst),
            .we   (write && (wr_bank == 1'(b))),
            .waddr(waddr),
            .wdata(in_data),
            .rdata(bank_data[b])
        );
    end

    // A write can only target a non-full bank and a transfer only a full one,
    // so completion and release never collide on the same flag.
    always_comb begin
        full_nxt = full;
        if (xfer) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (write && wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= '0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            full <= full_nxt;
            if (write) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_last) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (xfer) begin
                rd_bank   <= ~rd_bank;
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign frame_valid = full[rd_bank];
    assign frame_data  = rd_bank ? bank_data[1] : bank_data[0];

endmodule

// File: doc/fft_frame_buffer.md
# fft_frame_buffer

Ping-pong frame buffer that sits directly downstream of the FIR filter stage. It collects consecutive 16-bit filtered samples into fixed-length frames and presents each complete frame in parallel to the FFT stage over a valid/ready handshake. Two banks let the FIR output keep streaming while the FFT consumes the previous frame.

## Interface
Parameters:
- DW, 16, sample width in bits; matches the FIR output width.
- N, 16, samples per frame; must be a power of 2.
- LOG2N, 4, log2(N).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  one sample is offered on in_data in this cycle; driven from FIR fir_valid qualified by the upstream data strobe.
- in_data  in  DW  signed sample (FIR fir_d).
- frame_valid  out  1  a complete frame is on frame_data.
- frame_ready  in  1  the FFT accepts the frame this cycle.
- frame_data  out  N*DW  frame; slot s occupies bits [s*DW +: DW].
- frame_cnt  out  8  count of accepted frames; wraps 255 -> 0.
- overflow  out  1  sticky; at least one sample was dropped.

## Operation
- Storage: two banks (0, 1), each holding N x DW registers. Each bank has a full flag.
- Write side: wr_bank (1 bit) and wr_cnt (LOG2N bits).
  - When in_valid=1 and the bank at wr_bank is not full: write in_data to slot wr_cnt (bit-reversed address when configured), then increment wr_cnt.
  - When wr_cnt=N-1 and a write occurs: set full[wr_bank], toggle wr_bank, and let wr_cnt wrap to 0.
- Drop: when in_valid=1 and full[wr_bank]=1, the sample is discarded, overflow is set to 1, and wr_cnt is unchanged.
- Read side: rd_bank (1 bit).
  - frame_valid = full[rd_bank].
  - frame_data = contents of bank rd_bank, all registered outputs.
- Handshake: the frame transfers when frame_valid & frame_ready. In that cycle, clear full[rd_bank], toggle rd_bank, and increment frame_cnt.
  - frame_ready with frame_valid=0 has no effect.
  - frame_valid, once high, stays high and frame_data stays stable until the transfer.
- Simultaneous events:
  - A write completing one bank and a transfer releasing the other bank in the same cycle both take effect.
  - A sample arriving in the same cycle its target bank is released is still dropped, because the full flag is sampled before the edge.
- No arithmetic on samples; values pass bit-exact, including 0x8000.
- overflow is cleared only by rst.

## Timing
- Reset values:
  - frame_valid=0, frame_data=0 (all bank registers 0), frame_cnt=0, overflow=0.
  - wr_bank=0, rd_bank=0, wr_cnt=0, both full flags 0.
- Reset mid-frame discards the partial frame and any pending frames; the first sample after reset goes to bank 0, slot 0.
- Latency: the Nth sample is captured at edge k, and frame_valid=1 from edge k to edge k+1. Zero added latency beyond sample capture.
- Throughput: one sample per cycle sustained, provided each frame is accepted within N cycles of its frame_valid rising.
- After a transfer at edge t, frame_valid reflects the other bank from t onward; back-to-back frames are possible.

## Configuration
- FFT_FRAME_BUFFER_BITREV_EN
  - Defined: sample i of a frame (arrival order 0..N-1) is written to slot bitrev_LOG2N(i), so the FFT receives decimation-in-time input order directly.
  - Undefined: sample i is written to slot i.
- Handshake and timing are identical in both builds.

## Structure
- Shared package fft_pkg holds:
  - DW, N, LOG2N constants;
  - the frame-count width (8);
  - a bit-reverse function over LOG2N bits, which the FFT stage reuses.
- One sub-module: fft_frame_bank. It holds N x DW registers with async reset, write enable, a LOG2N write address and a flat N*DW read bus. Instantiate it twice; the top contains the pointers, full flags, handshake logic and output mux.

## Test plan
- Basic frame: frame_ready=1, 16 consecutive samples 0x0001..0x0010 → frame_valid high for exactly one cycle after the 16th sample, slot0=0x0001, slot15=0x0010, frame_cnt=1.
- Backpressure and overflow: frame_ready=0, 33 samples 0x0000..0x0020 → both banks full after 32 samples; sample 0x0020 dropped and overflow=1. Then pulse frame_ready twice → frames read out as 0x0000..0x000F, then 0x0010..0x001F; frame_cnt=2; overflow stays 1.
- Simultaneous: bank 0 full and presented; the 16th sample of bank 1 arrives in the same cycle frame_ready=1 → bank 0 released and bank 1 full at the same edge; frame_valid stays high, showing bank 1.
- Reset mid-frame: assert rst after 7 samples, then feed 16 samples 0x0100..0x010F → one frame with slot0=0x0100; no residue from the earlier samples.
- Bit-reverse (macro defined): samples 0x0000..0x000F → slot1=0x0008, slot2=0x0004, slot15=0x000F. With the macro undefined, slot1=0x0001.
- Sign passthrough: samples 0x8000, 0xFFFF, 0x7FFF → appear unchanged in their slots.
